multicycle_controller: RTL and testbench

Multi-cycle FSM controller for the team's 6-bit-opcode CPU.
- Sequences fetch, decode, execute, memory and writeback over several cycles, with a ready handshake to a shared instruction/data memory.
- Tracks return-stack occupancy, faults on overflow, underflow or memory timeout.
- Sits between the instruction register and the datapath, driving the same control strobes as the single-cycle decoder.

---
 rtl/multicycle_controller_if.sv | 25 ++
 rtl/multicycle_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller (master) and the
// shared instruction/data memory (slave).
interface multicycle_controller_if;
    logic mem_req;
    logic memoryread;
    logic memorywrite;
    logic ifetch;
    logic mem_ready;

    modport master (
        output mem_req,
        output memoryread,
        output memorywrite,
        output ifetch,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  memoryread,
        input  memorywrite,
        input  ifetch,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 6-bit-opcode CPU: fetch/decode/exec/mem/wb
// sequencing, return-stack depth tracking, fault on stack misuse or memory timeout.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes trap to FAULT (default: NOP).
module multicycle_controller #(
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [5:0]                     code,
    input  logic                           ze,
    input  logic                           c,
    multicycle_controller_if.master        mem,
    output logic                           ir_load,
    output logic                           pc_inc,
    output logic                           writeReg,
    output logic                           selRR2,
    output logic                           selALU2,
    output logic                           selpc,
    output logic                           ldz,
    output logic                           ldc,
    output logic                           selz,
    output logic                           selc,
    output logic                           push,
    output logic                           pop,
    output logic [1:0]                     selWD,
    output logic [1:0]                     selRet,
    output logic [2:0]                     ALUfn,
    output logic                           stack_full,
    output logic                           stack_empty,
    output logic                           fault
);
    localparam int unsigned DW      = $clog2(STACK_DEPTH + 1);
    localparam int unsigned TW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_t;

    typedef enum logic [3:0] {
        K_ALUI, K_ALUR, K_SHIFT, K_LOAD, K_STORE, K_BRANCH,
        K_JUMP, K_CALL, K_RET, K_ILLEGAL
    } kind_t;

    state_t        state_q, state_d;
    kind_t         kind;
    logic [5:0]    op_q;
    logic [DW-1:0] depth_q;
    logic [TW-1:0] timer_q, timer_d;
    logic          is_full, is_empty, expire;
    logic          mem_req_c, memoryread_c, memorywrite_c, ifetch_c;

    assign is_full  = (depth_q == DW'(STACK_DEPTH));
    assign is_empty = (depth_q == DW'(0));
    // The wait cycle that would bring the count up to MEM_TIMEOUT ends the access.
    assign expire   = (MEM_TIMEOUT != 0) && !mem.mem_ready && (timer_q == TW'(TO_LAST));

    // Opcode class of the latched instruction.
    always_comb begin
        kind = K_ILLEGAL;
        casez (op_q)
            6'b00????: kind = K_ALUI;
            6'b01????: kind = K_ALUR;
            6'b110???: kind = K_SHIFT;
            6'b10000?: kind = K_LOAD;
            6'b10001?: kind = K_STORE;
            6'b101???: kind = K_BRANCH;
            6'b11100?: kind = K_JUMP;
            6'b11101?: kind = K_CALL;
            6'b111100: kind = K_RET;
            default:   kind = K_ILLEGAL;
        endcase
    end

    // Next state and control strobes.
    always_comb begin
        state_d       = state_q;
        ir_load       = 1'b0;
        pc_inc        = 1'b0;
        writeReg      = 1'b0;
        selRR2        = 1'b0;
        selALU2       = 1'b0;
        selpc         = 1'b0;
        ldz           = 1'b0;
        ldc           = 1'b0;
        selz          = 1'b0;
        selc          = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        selWD         = 2'b00;
        selRet        = 2'b00;
        ALUfn         = 3'b000;
        mem_req_c     = 1'b0;
        memoryread_c  = 1'b0;
        memorywrite_c = 1'b0;
        ifetch_c      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req_c    = 1'b1;
                memoryread_c = 1'b1;
                ifetch_c     = 1'b1;
                if (expire) begin
                    state_d = S_FAULT;
                end else if (mem.mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                case (kind)
                    K_ALUI: begin
                        ALUfn    = op_q[3:1];
                        selALU2  = 1'b1;
                        ldz      = 1'b1;
                        ldc      = 1'b1;
                        writeReg = 1'b1;
                    end
                    K_ALUR: begin
                        ALUfn    = op_q[3:1];
                        ldz      = 1'b1;
                        ldc      = 1'b1;
                        writeReg = 1'b1;
                    end
                    K_SHIFT: begin
                        selz     = 1'b1;
                        selc     = 1'b1;
                        ldz      = 1'b1;
                        ldc      = 1'b1;
                        selWD    = 2'b10;
                        writeReg = 1'b1;
                    end
                    K_LOAD, K_STORE: state_d = S_MEM;
                    K_BRANCH: begin
                        case (op_q[2:1])
                            2'b00:   selpc = ze;
                            2'b01:   selpc = !ze;
                            2'b10:   selpc = c;
                            default: selpc = !c;
                        endcase
                    end
                    K_JUMP: begin
                        selRet = 2'b10;
                        selpc  = 1'b1;
                    end
                    K_CALL: begin
                        if (is_full) begin
                            state_d = S_FAULT;
                        end else begin
                            selRet = 2'b10;
                            selpc  = 1'b1;
                            push   = 1'b1;
                        end
                    end
                    K_RET: begin
                        if (is_empty) begin
                            state_d = S_FAULT;
                        end else begin
                            selRet = 2'b01;
                            selpc  = 1'b1;
                            pop    = 1'b1;
                        end
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_FAULT;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                selRR2        = 1'b1;
                mem_req_c     = 1'b1;
                memoryread_c  = (kind == K_LOAD);
                memorywrite_c = (kind == K_STORE);
                if (expire) begin
                    state_d = S_FAULT;
                end else if (mem.mem_ready) begin
                    state_d = (kind == K_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                selRR2   = 1'b1;
                selWD    = 2'b01;
                writeReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Wait-cycle counter: runs only while a memory access is stalled.
    always_comb begin
        timer_d = '0;
        if ((MEM_TIMEOUT != 0) && (state_d == state_q) && !mem.mem_ready &&
            ((state_q == S_FETCH) || (state_q == S_MEM))) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            depth_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (state_q == S_DECODE) begin
                op_q <= code;
            end
            if (push) begin
                depth_q <= depth_q + DW'(1);
            end else if (pop) begin
                depth_q <= depth_q - DW'(1);
            end
        end
    end

    assign mem.mem_req     = mem_req_c;
    assign mem.memoryread  = memoryread_c;
    assign mem.memorywrite = memorywrite_c;
    assign mem.ifetch      = ifetch_c;
    assign stack_full      = is_full;
    assign stack_empty     = is_empty;
    assign fault           = (state_q == S_FAULT);
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (STACK_DEPTH=2, MEM_TIMEOUT=4);
// inputs change on the falling edge, outputs are compared 1 ns later.
module tb_multicycle_controller;
    logic       clk;
    logic       rst;
    logic [5:0] code;
    logic       ze;
    logic       c;
    logic       mem_ready;
    logic       ir_load, pc_inc, writeReg, selRR2, selALU2, selpc;
    logic       ldz, ldc, selz, selc, push, pop;
    logic [1:0] selWD, selRet;
    logic [2:0] ALUfn;
    logic       stack_full, stack_empty, fault;
    logic [22:0] all_strobes;
    int checks;
    int errors;

    multicycle_controller_if mem_bus ();
    assign mem_bus.mem_ready = mem_ready;

    multicycle_controller #(.STACK_DEPTH(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .code(code), .ze(ze), .c(c), .mem(mem_bus),
        .ir_load(ir_load), .pc_inc(pc_inc), .writeReg(writeReg), .selRR2(selRR2),
        .selALU2(selALU2), .selpc(selpc), .ldz(ldz), .ldc(ldc), .selz(selz),
        .selc(selc), .push(push), .pop(pop), .selWD(selWD), .selRet(selRet),
        .ALUfn(ALUfn), .stack_full(stack_full), .stack_empty(stack_empty), .fault(fault)
    );

    assign all_strobes = {ir_load, pc_inc, mem_bus.ifetch, mem_bus.mem_req,
                          mem_bus.memoryread, mem_bus.memorywrite, writeReg, selRR2,
                          selALU2, selpc, ldz, ldc, selz, selc, push, pop,
                          selWD, selRet, ALUfn};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reset, release, and leave the FSM in a FETCH cycle that completes.
    task automatic restart();
        @(negedge clk); rst = 1'b0; mem_ready = 1'b1; ze = 1'b0; c = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; code = 6'd0; ze = 1'b0; c = 1'b0; mem_ready = 1'b0;
        #3;
        checks++;
        if (all_strobes !== 23'd0) begin
            errors++; $display("FAIL reset_strobes: got %h expected 000000", all_strobes);
        end
        checks++;
        if ({stack_full, stack_empty, fault} !== 3'b010) begin
            errors++; $display("FAIL reset_flags: got %b expected 010", {stack_full, stack_empty, fault});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_alu();
        @(negedge clk); code = 6'b010110; mem_ready = 1'b1; rst = 1'b1; #1;
        checks++;
        if (all_strobes !== 23'd0) begin
            errors++; $display("FAIL alu_idle: got %h expected 000000", all_strobes);
        end
        @(negedge clk); #1;
        checks++;
        if ({ir_load, pc_inc, mem_bus.ifetch, mem_bus.mem_req, mem_bus.memoryread} !== 5'b11111) begin
            errors++; $display("FAIL alu_fetch: got %b expected 11111",
                {ir_load, pc_inc, mem_bus.ifetch, mem_bus.mem_req, mem_bus.memoryread});
        end
        @(negedge clk); #1;
        checks++;
        if (all_strobes !== 23'd0) begin
            errors++; $display("FAIL alu_decode: got %h expected 000000", all_strobes);
        end
        @(negedge clk); #1;
        checks++;
        if ({ALUfn, ldz, ldc, writeReg, selALU2} !== 7'b011_1110) begin
            errors++; $display("FAIL alu_exec: got %b expected 0111110", {ALUfn, ldz, ldc, writeReg, selALU2});
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_bus.ifetch, mem_bus.mem_req, ir_load} !== 3'b111) begin
            errors++; $display("FAIL alu_refetch: got %b expected 111", {mem_bus.ifetch, mem_bus.mem_req, ir_load});
        end
    endtask

    task automatic test_load_store();
        code = 6'b100000;
        @(negedge clk); #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (all_strobes !== 23'd0) begin
            errors++; $display("FAIL load_exec: got %h expected 000000", all_strobes);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = (i == 3); #1;
            checks++;
            if ({mem_bus.mem_req, mem_bus.memoryread, mem_bus.memorywrite, selRR2, ALUfn, writeReg} !== 8'b1101_000_0) begin
                errors++; $display("FAIL load_mem[%0d]: got %b expected 11010000", i,
                    {mem_bus.mem_req, mem_bus.memoryread, mem_bus.memorywrite, selRR2, ALUfn, writeReg});
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({selWD, writeReg, selRR2, mem_bus.mem_req, mem_bus.memoryread} !== 6'b011100) begin
            errors++; $display("FAIL load_wb: got %b expected 011100",
                {selWD, writeReg, selRR2, mem_bus.mem_req, mem_bus.memoryread});
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_bus.ifetch, mem_bus.mem_req, ir_load} !== 3'b111) begin
            errors++; $display("FAIL load_refetch: got %b expected 111", {mem_bus.ifetch, mem_bus.mem_req, ir_load});
        end
        code = 6'b100010;
        @(negedge clk); #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (all_strobes !== 23'd0) begin
            errors++; $display("FAIL store_exec: got %h expected 000000", all_strobes);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_ready = (i == 1); #1;
            checks++;
            if ({mem_bus.mem_req, mem_bus.memoryread, mem_bus.memorywrite, selRR2, writeReg} !== 5'b10110) begin
                errors++; $display("FAIL store_mem[%0d]: got %b expected 10110", i,
                    {mem_bus.mem_req, mem_bus.memoryread, mem_bus.memorywrite, selRR2, writeReg});
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_bus.ifetch, mem_bus.mem_req, writeReg, selWD} !== 5'b11000) begin
            errors++; $display("FAIL store_no_wb: got %b expected 11000",
                {mem_bus.ifetch, mem_bus.mem_req, writeReg, selWD});
        end
    endtask

    task automatic test_branch();
        logic [8:0] vec [6];
        // {code, ze, c, expected selpc}
        vec = '{9'b101000_1_0_1, 9'b101000_0_0_0, 9'b101111_0_0_1,
                9'b101111_0_1_0, 9'b101100_0_1_1, 9'b101011_1_0_0};
        for (int i = 0; i < 6; i++) begin
            code = vec[i][8:3];
            @(negedge clk); #1;
            @(negedge clk); ze = vec[i][2]; c = vec[i][1]; #1;
            checks++;
            if ({selpc, selRet, writeReg} !== {vec[i][0], 3'b000}) begin
                errors++; $display("FAIL branch[%0d]: got %b expected %b", i,
                    {selpc, selRet, writeReg}, {vec[i][0], 3'b000});
            end
            @(negedge clk); #1;
        end
        ze = 1'b0; c = 1'b0;
    endtask

    task automatic test_stack();
        logic [11:0] ops [4];
        // {code, expected {push,pop,selpc,selRet}, expected stack_full afterwards}
        ops = '{12'b111010_10110_0, 12'b111011_10110_1, 12'b111100_01101_0, 12'b111010_10110_1};
        for (int i = 0; i < 4; i++) begin
            code = ops[i][11:6];
            @(negedge clk); #1;
            @(negedge clk); #1;
            checks++;
            if ({push, pop, selpc, selRet} !== ops[i][5:1]) begin
                errors++; $display("FAIL stack_exec[%0d]: got %b expected %b", i,
                    {push, pop, selpc, selRet}, ops[i][5:1]);
            end
            @(negedge clk); #1;
            checks++;
            if (stack_full !== ops[i][0]) begin
                errors++; $display("FAIL stack_full[%0d]: got %b expected %b", i, stack_full, ops[i][0]);
            end
        end
        code = 6'b111010;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if ({push, pop, selpc, selRet} !== 5'b00000) begin
            errors++; $display("FAIL call_overflow_exec: got %b expected 00000", {push, pop, selpc, selRet});
        end
        @(negedge clk); #1;
        checks++;
        if ({fault, stack_full, stack_empty, all_strobes} !== {3'b110, 23'd0}) begin
            errors++; $display("FAIL call_overflow_fault: got %b/%h expected 110/000000",
                {fault, stack_full, stack_empty}, all_strobes);
        end
        restart();
        code = 6'b111100;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if ({push, pop, selpc, selRet} !== 5'b00000) begin
            errors++; $display("FAIL ret_underflow_exec: got %b expected 00000", {push, pop, selpc, selRet});
        end
        @(negedge clk); #1;
        checks++;
        if ({fault, stack_empty, all_strobes} !== {2'b11, 23'd0}) begin
            errors++; $display("FAIL ret_underflow_fault: got %b/%h expected 11/000000",
                {fault, stack_empty}, all_strobes);
        end
    endtask

    task automatic test_timeout();
        restart();
        code = 6'b010000;
        @(negedge clk); #1;
        @(negedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b0; #1;
            checks++;
            if ({mem_bus.mem_req, mem_bus.ifetch, ir_load, fault} !== 4'b1100) begin
                errors++; $display("FAIL timeout_wait[%0d]: got %b expected 1100", i,
                    {mem_bus.mem_req, mem_bus.ifetch, ir_load, fault});
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({fault, all_strobes} !== {1'b1, 23'd0}) begin
            errors++; $display("FAIL timeout_fault: got %b/%h expected 1/000000", fault, all_strobes);
        end
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got %b expected 1", fault);
        end
        rst = 1'b0; #1;
        checks++;
        if ({fault, stack_empty} !== 2'b01) begin
            errors++; $display("FAIL timeout_reset: got %b expected 01", {fault, stack_empty});
        end
    endtask

    task automatic test_reset_mid_mem();
        restart();
        code = 6'b100000;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if ({mem_bus.mem_req, mem_bus.memoryread} !== 2'b11) begin
            errors++; $display("FAIL midmem_before: got %b expected 11", {mem_bus.mem_req, mem_bus.memoryread});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({all_strobes, stack_empty} !== {23'd0, 1'b1}) begin
            errors++; $display("FAIL midmem_reset: got %h/%b expected 000000/1", all_strobes, stack_empty);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ill [2];
        ill = '{6'b111110, 6'b100110};
        for (int i = 0; i < 2; i++) begin
            restart();
            code = ill[i];
            @(negedge clk); #1;
            @(negedge clk); #1;
            checks++;
            if (all_strobes !== 23'd0) begin
                errors++; $display("FAIL illegal_exec[%0d]: got %h expected 000000", i, all_strobes);
            end
            @(negedge clk); #1;
            checks++;
`ifdef ILLEGAL_TRAP_EN
            if ({fault, mem_bus.mem_req, mem_bus.ifetch} !== 3'b100) begin
                errors++; $display("FAIL illegal_next[%0d]: got %b expected 100", i,
                    {fault, mem_bus.mem_req, mem_bus.ifetch});
            end
`else
            if ({fault, mem_bus.mem_req, mem_bus.ifetch} !== 3'b011) begin
                errors++; $display("FAIL illegal_next[%0d]: got %b expected 011", i,
                    {fault, mem_bus.mem_req, mem_bus.ifetch});
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_stack();
        test_timeout();
        test_reset_mid_mem();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
